// File: rtl/fw_hazard_if.sv
// Handshake bundle between the pipeline control and fw_hazard_unit.
// HAZ_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface fw_hazard_if #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NSRC = 2
);
  logic [NSRC*AW-1:0] ex_src;
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0]    id_src_valid;
  logic               memread_ex;
  logic [AW-1:0]      rd_ex;
  logic               regwrite_mem;
  logic [AW-1:0]      rd_mem;
  logic               regwrite_wb;
  logic [AW-1:0]      rd_wb;
  logic               md_start;
  logic               id_md_use;
  logic               branch_taken;
  logic [2*NSRC-1:0]  forward;
  logic               stall;
  logic               bubble_ex;
  logic               flush_id;
  logic               md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]        stall_cnt;
  logic [31:0]        flush_cnt;
`endif

  modport master (
    output ex_src, id_src, id_src_valid, memread_ex, rd_ex,
           regwrite_mem, rd_mem, regwrite_wb, rd_wb,
           md_start, id_md_use, branch_taken,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    input  forward, stall, bubble_ex, flush_id, md_busy
  );

  modport slave (
    input  ex_src, id_src, id_src_valid, memread_ex, rd_ex,
           regwrite_mem, rd_mem, regwrite_wb, rd_wb,
           md_start, id_md_use, branch_taken,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    output forward, stall, bubble_ex, flush_id, md_busy
  );
endinterface

// File: rtl/fw_hazard_unit.sv
// Forwarding, load-use / mult-div hazard and branch flush control for the 5-stage core.
// Optional stall/flush performance counters under HAZ_PERF_CNT_EN.
module fw_hazard_unit #(
  parameter int unsigned AW     = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned MD_LAT = 4
) (
  input logic        clk,
  input logic        reset,
  fw_hazard_if.slave hz
);
  localparam int unsigned CW = $clog2(MD_LAT + 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*NSRC-1:0] fwd;
  logic              lu, md_busy, md_hazard, md_accept;
  logic              stall_c, bubble_c, flush_c;

  always_comb begin
    fwd = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (hz.regwrite_mem && hz.rd_mem == hz.ex_src[i*AW +: AW] && hz.rd_mem != '0)
        fwd[2*i +: 2] = 2'd1;
      else if (hz.regwrite_wb && hz.rd_wb == hz.ex_src[i*AW +: AW] && hz.rd_wb != '0)
        fwd[2*i +: 2] = 2'd2;
    end
    if (reset) fwd = '0;
  end

  always_comb begin
    lu = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++)
      if (hz.id_src_valid[i] && hz.id_src[i*AW +: AW] == hz.rd_ex) lu = 1'b1;
    lu = lu && hz.memread_ex && hz.rd_ex != '0;
  end

  assign md_busy   = (state_q == MD_BUSY);
  assign md_hazard = hz.id_md_use && md_busy;

  // A taken branch discards the ID instruction, so its hazards never stall.
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (!reset) begin
      if (hz.branch_taken) begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
      end else if (lu || md_hazard) begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
    end
  end

  assign md_accept = hz.md_start && !stall_c && !hz.branch_taken && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: if (md_accept) begin
        state_d = MD_BUSY;
        cnt_d   = CW'(MD_LAT - 1);
      end
      MD_BUSY: if (cnt_q == '0) state_d = MD_IDLE;
               else             cnt_d   = cnt_q - CW'(1);
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.forward   = fwd;
  assign hz.stall     = stall_c;
  assign hz.bubble_ex = bubble_c;
  assign hz.flush_id  = flush_c;
  assign hz.md_busy   = md_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_c ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = flush_c ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fw_hazard_unit.sv
// Self-checking bench for fw_hazard_unit (AW=5, NSRC=2, MD_LAT=4).
// Combinational vectors from a table, multi-cycle sequences by hand, all through a scoreboard queue.
module tb_fw_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fw_hazard_if #(.AW(5), .NSRC(2)) hz();

  fw_hazard_unit #(.AW(5), .NSRC(2), .MD_LAT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  typedef struct {
    logic [3:0] fwd;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [4:0] ex0, ex1, id0, id1;
    logic [1:0] val;
    logic       mr;
    logic [4:0] rdex;
    logic       rwm;
    logic [4:0] rdm;
    logic       rww;
    logic [4:0] rdw;
    logic       mduse;
    logic       br;
    logic [3:0] efwd;
    logic       estall, ebub, eflush;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    hz.ex_src = '0; hz.id_src = '0; hz.id_src_valid = '0;
    hz.memread_ex = 1'b0; hz.rd_ex = '0;
    hz.regwrite_mem = 1'b0; hz.rd_mem = '0;
    hz.regwrite_wb = 1'b0; hz.rd_wb = '0;
    hz.md_start = 1'b0; hz.id_md_use = 1'b0; hz.branch_taken = 1'b0;
  endtask

  task automatic expect_now(input logic [3:0] f, input logic s, input logic b,
                            input logic fl, input logic busy);
    exp_t e;
    e.fwd = f; e.stall = s; e.bubble = b; e.flush = fl; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".forward"}, 32'(hz.forward),   32'(e.fwd));
      chk({tag, ".stall"},   32'(hz.stall),     32'(e.stall));
      chk({tag, ".bubble"},  32'(hz.bubble_ex), 32'(e.bubble));
      chk({tag, ".flush"},   32'(hz.flush_id),  32'(e.flush));
      chk({tag, ".busy"},    32'(hz.md_busy),   32'(e.busy));
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load-use match on ID operand 1 against a load to r8.
  task automatic set_lu();
    hz.memread_ex = 1'b1; hz.rd_ex = 5'd8;
    hz.id_src = {5'd8, 5'd0}; hz.id_src_valid = 2'b10;
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ex0  ex1  id0  id1  val    mr rdex rwm rdm rww rdw  mu br  efwd    s  b  f
    vecs[0]  = '{5'd5, 5'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 1, 5'd5, 1, 5'd5, 0, 0, 4'b0001, 0, 0, 0};
    vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 5'd5, 1, 5'd5, 0, 0, 4'b0010, 0, 0, 0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 4'b0000, 0, 0, 0};
    vecs[3]  = '{5'd3, 5'd7, 5'd0, 5'd0, 2'b00, 0, 5'd0, 1, 5'd7, 1, 5'd3, 0, 0, 4'b0110, 0, 0, 0};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 4'b0000, 0, 0, 0};
    vecs[5]  = '{5'd0, 5'd0, 5'd2, 5'd8, 2'b10, 1, 5'd8, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 1, 1, 0};
    vecs[6]  = '{5'd0, 5'd0, 5'd2, 5'd8, 2'b01, 1, 5'd8, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 0, 0, 0};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 0, 0, 0};
    vecs[8]  = '{5'd9, 5'd9, 5'd9, 5'd1, 2'b01, 1, 5'd9, 0, 5'd0, 1, 5'd9, 0, 0, 4'b1010, 1, 1, 0};
    vecs[9]  = '{5'd0, 5'd0, 5'd2, 5'd8, 2'b10, 1, 5'd8, 0, 5'd0, 0, 5'd0, 0, 1, 4'b0000, 0, 1, 1};
    vecs[10] = '{5'd4, 5'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 1, 5'd4, 0, 5'd0, 0, 1, 4'b0001, 0, 1, 1};
    vecs[11] = '{5'd0, 5'd0, 5'd8, 5'd8, 2'b11, 0, 5'd8, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 0, 0, 0};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 4'b0000, 0, 0, 0};

    idle_inputs();

    // Reset: matching inputs, branch and md_start must all be masked.
    next_cycle();
    reset = 1'b1;
    hz.ex_src = {5'd6, 5'd5}; hz.regwrite_mem = 1'b1; hz.rd_mem = 5'd5;
    hz.regwrite_wb = 1'b1; hz.rd_wb = 5'd6; set_lu();
    hz.branch_taken = 1'b1; hz.md_start = 1'b1;
    expect_now(4'b0000, 0, 0, 0, 0); check_out("reset");
    next_cycle();
    reset = 1'b0; idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 0); check_out("post_reset");

    // Combinational table with the MD unit idle.
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      hz.ex_src = {vecs[i].ex1, vecs[i].ex0};
      hz.id_src = {vecs[i].id1, vecs[i].id0};
      hz.id_src_valid = vecs[i].val;
      hz.memread_ex = vecs[i].mr; hz.rd_ex = vecs[i].rdex;
      hz.regwrite_mem = vecs[i].rwm; hz.rd_mem = vecs[i].rdm;
      hz.regwrite_wb = vecs[i].rww; hz.rd_wb = vecs[i].rdw;
      hz.id_md_use = vecs[i].mduse; hz.branch_taken = vecs[i].br;
      hz.md_start = 1'b0;
      expect_now(vecs[i].efwd, vecs[i].estall, vecs[i].ebub, vecs[i].eflush, 0);
      check_out($sformatf("vec%0d", i));
    end

    // MD occupancy: start at cycle 0, busy cycles 1..4, low at 5.
    next_cycle(); idle_inputs(); hz.md_start = 1'b1;
    expect_now(4'b0000, 0, 0, 0, 0); check_out("md_c0");
    next_cycle(); idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 1); check_out("md_c1");
    next_cycle(); hz.id_md_use = 1'b1; set_lu();
    expect_now(4'b0000, 1, 1, 0, 1); check_out("md_c2_dual_hazard");
    next_cycle(); idle_inputs(); hz.md_start = 1'b1; hz.id_md_use = 1'b1;
    expect_now(4'b0000, 1, 1, 0, 1); check_out("md_c3_second_start");
    next_cycle(); idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 1); check_out("md_c4");
    next_cycle();
    expect_now(4'b0000, 0, 0, 0, 0); check_out("md_c5");
    next_cycle();
    expect_now(4'b0000, 0, 0, 0, 0); check_out("md_c6");

    // md_start blocked by a load-use stall.
    next_cycle(); set_lu(); hz.md_start = 1'b1;
    expect_now(4'b0000, 1, 1, 0, 0); check_out("md_start_lu");
    next_cycle(); idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 0); check_out("md_start_lu_next");

    // Branch beats load-use; md_start on a flush is dropped.
    next_cycle(); set_lu(); hz.branch_taken = 1'b1; hz.md_start = 1'b1;
    expect_now(4'b0000, 0, 1, 1, 0); check_out("branch_lu");
    next_cycle(); idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 0); check_out("branch_next");

    // Reset in BUSY cycle 2, then a fresh full window.
    next_cycle(); hz.md_start = 1'b1;
    expect_now(4'b0000, 0, 0, 0, 0); check_out("rst_c0");
    next_cycle(); idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 1); check_out("rst_c1");
    next_cycle(); reset = 1'b1;
    hz.ex_src = {5'd0, 5'd5}; hz.regwrite_mem = 1'b1; hz.rd_mem = 5'd5;
    set_lu(); hz.id_md_use = 1'b1;
    expect_now(4'b0000, 0, 0, 0, 1); check_out("rst_during");
    next_cycle(); reset = 1'b0; idle_inputs();
    expect_now(4'b0000, 0, 0, 0, 0); check_out("rst_after");
    next_cycle(); hz.md_start = 1'b1;
    expect_now(4'b0000, 0, 0, 0, 0); check_out("fresh_c0");
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); idle_inputs();
      expect_now(4'b0000, 0, 0, 0, (c <= 4) ? 1'b1 : 1'b0);
      check_out($sformatf("fresh_c%0d", c));
    end

`ifdef HAZ_PERF_CNT_EN
    next_cycle(); reset = 1'b1; idle_inputs();
    next_cycle(); reset = 1'b0;
    chk("perf_stall_rst", hz.stall_cnt, 32'd0);
    chk("perf_flush_rst", hz.flush_cnt, 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); idle_inputs(); set_lu();
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); idle_inputs(); hz.branch_taken = 1'b1;
    end
    next_cycle(); idle_inputs();
    chk("perf_stall_cnt", hz.stall_cnt, 32'd3);
    chk("perf_flush_cnt", hz.flush_cnt, 32'd2);
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
    chk("perf_stall_clr", hz.stall_cnt, 32'd0);
    chk("perf_flush_clr", hz.flush_cnt, 32'd0);
`endif

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fw_hazard_unit.md
Name: fw_hazard_unit

Overview:
Parametrised forwarding and hazard controller for the 5-stage pipelined MIPS core. It is the successor to the per-operand forwarding unit.
- Forwarding mux selects for NSRC EX-stage source operands.
- Load-use stall detection.
- Multi-cycle mult/div occupancy tracking, with a small FSM and counter.
- Branch flush arbitration.
It sits beside the ID/EX pipeline registers and drives the PC/IF-ID enables, the EX bubble and the EX operand muxes.

Parameters:
AW, 5, register address width; address 0 is the hardwired zero register.
NSRC, 2, number of source operands per instruction (>=1).
MD_LAT, 4, mult/div occupancy in cycles (>=2).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
ex_src  in  NSRC*AW  EX-stage source register addresses; operand i is at [i*AW +: AW]
id_src  in  NSRC*AW  ID-stage source register addresses
id_src_valid  in  NSRC  bit i high means ID operand i is actually read
memread_ex  in  1  EX instruction is a load
rd_ex  in  AW  EX destination register
regwrite_mem  in  1  MEM instruction writes the register file
rd_mem  in  AW  MEM destination register
regwrite_wb  in  1  WB instruction writes the register file
rd_wb  in  AW  WB destination register
md_start  in  1  ID instruction is a mult/div issue
id_md_use  in  1  ID instruction reads HI/LO or issues mult/div
branch_taken  in  1  EX resolved a taken branch or jump
forward  out  2*NSRC  per-operand select at [2i+1:2i]; 0 = register file, 1 = MEM, 2 = WB
stall  out  1  hold PC and IF/ID register
bubble_ex  out  1  insert NOP into ID/EX
flush_id  out  1  squash IF/ID contents
md_busy  out  1  mult/div unit occupied

Behaviour:
- Forwarding is combinational and evaluated on every input change, with full sensitivity.
  - Operand i gets 1 if regwrite_mem && rd_mem==ex_src[i] && rd_mem!=0.
  - Otherwise it gets 2 if regwrite_wb && rd_wb==ex_src[i] && rd_wb!=0.
  - Otherwise it gets 0.
  - MEM beats WB. The value 3 is never driven. forward is 0 while reset is high.
- Load-use: lu = memread_ex && rd_ex!=0 && (some i has id_src_valid[i] && id_src[i]==rd_ex).
- MD FSM, all updates on the clk rising edge:
  - States: IDLE and BUSY. Counter cnt has width clog2(MD_LAT+1).
  - IDLE -> BUSY when md_start && !stall && !branch_taken; cnt loads MD_LAT-1.
  - In BUSY, cnt decrements each cycle. When cnt==0 the FSM returns to IDLE on that edge.
  - md_busy is high exactly when the state is BUSY. Each accepted op therefore holds md_busy for MD_LAT cycles.
- md_hazard = id_md_use && md_busy. A second md_start while BUSY is never accepted; it stalls in ID.
- Arbitration:
  - If branch_taken: flush_id=1, bubble_ex=1, stall=0. The branch wins and the ID instruction is discarded, so any lu or md_hazard on it is ignored.
  - Else if lu || md_hazard: stall=1, bubble_ex=1, flush_id=0.
  - Else: all three are 0.
- stall, bubble_ex and flush_id are combinational, forced to 0 while reset is high.
- Reset:
  - On an edge with reset high, state=IDLE, cnt=0, and md_busy=0 from that edge.
  - This holds mid-BUSY; the in-flight op is abandoned.
  - md_start is ignored while reset is high.
- Boundaries:
  - rd_ex==0 never stalls.
  - An invalid operand matching rd_ex never stalls.
  - A load-use and an md_hazard in the same cycle produce a single stall.
  - On a flush, md_start is not accepted.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- When defined, add two outputs:
  - stall_cnt (32): increments on each clk edge where stall=1.
  - flush_cnt (32): increments on each edge where flush_id=1.
  - Both wrap at 2^32-1 -> 0 and clear to 0 on reset.
- When undefined, the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Forward priority: ex_src[0]=5, regwrite_mem=1 rd_mem=5, regwrite_wb=1 rd_wb=5 -> forward[1:0]=1. Then drop regwrite_mem -> 2. Then rd_wb=0 with ex_src=0 -> 0.
- Load-use: memread_ex=1 rd_ex=8, id_src[1]=8 valid -> stall=1, bubble_ex=1 for that cycle. Clearing id_src_valid[1] -> stall=0. rd_ex=0 -> stall=0.
- MD occupancy: md_start pulse at cycle 0 with MD_LAT=4 -> md_busy high in cycles 1-4, low in cycle 5. id_md_use=1 in cycle 2 -> stall=1. A second md_start in cycle 3 is not accepted.
- Branch priority: branch_taken=1 together with a load-use match -> flush_id=1, bubble_ex=1, stall=0. md_start in the same cycle leaves md_busy at 0.
- Reset mid-op: reset at cycle 2 of BUSY -> md_busy=0 next cycle. forward/stall are 0 during reset. A fresh md_start afterwards gives a full MD_LAT window.
- HAZ_PERF_CNT_EN: 3 load-use stalls and 2 branch flushes -> stall_cnt=3, flush_cnt=2. Reset -> both 0.
